// File: rtl/cpu_write_filter.sv
// CPU register-write front end: decodes bus writes into a one-cycle strobe with held address/data.
// Latency: a write sampled on m2 falling edge N is presented from edge N until edge N+1.
// Backpressure: none; writes arriving in the power-on guard or as RMW repeats are discarded.
module cpu_write_filter #(
    parameter logic [14:0] ADDR_MASK    = 15'h6100,
    parameter logic [14:0] ADDR_VALUE   = 15'h4100,
    parameter logic        ROMSEL_VALUE = 1'b1,
    parameter int          GUARD_CYCLES = 16,
    parameter logic        FILTER_RMW   = 1'b1
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic        wr_strobe,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        ready,
    output logic [7:0]  drop_count
);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A zero-length guard means the block comes out of reset already running.
    localparam logic [7:0] GUARD_INIT  = 8'(GUARD_CYCLES);
    localparam state_t     RESET_STATE = (GUARD_CYCLES == 0) ? ST_RUN : ST_GUARD;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  guard_cnt_q;
    logic [7:0]  guard_cnt_d;
    logic        prev_match_q;
    logic        match;
    logic        accept;
    logic        drop;

    // Bus decode: a write cycle with the right /ROMSEL level inside the address window.
    always_comb begin
        match = (cpu_rw_in == 1'b0)
             && (romsel == ROMSEL_VALUE)
             && ((cpu_addr_in & ADDR_MASK) == ADDR_VALUE);
    end

    // Guard/run sequencing and the accept/drop decision for the current edge.
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        accept      = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_GUARD: begin
                // Matches are ignored here, including on the edge the count hits zero.
                if (guard_cnt_q <= 8'd1) begin
                    guard_cnt_d = 8'd0;
                    state_d     = ST_RUN;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                if (match) begin
                    // The second and later writes of a consecutive run are RMW echoes.
                    if (FILTER_RMW && prev_match_q) begin
                        drop = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = RESET_STATE;
                guard_cnt_d = GUARD_INIT;
            end
        endcase
    end

    // State register; reset restarts the guard period.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            guard_cnt_q <= GUARD_INIT;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    // Registered outputs: strobe, held address/data, match history and saturating drop count.
    always_ff @(negedge m2 or posedge reset) begin
        if (reset) begin
            prev_match_q <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= 15'd0;
            wr_data      <= 8'd0;
            drop_count   <= 8'd0;
        end else begin
            prev_match_q <= match;
            wr_strobe    <= accept;
            if (accept) begin
                wr_addr <= cpu_addr_in;
                wr_data <= cpu_data_in;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Ready is a decode of the state register, so it carries no path from the bus.
    assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_cpu_write_filter.sv
// Directed bench for cpu_write_filter: default, RMW-filter-off and zero-guard instances share one bus.
// Latency: each bus() call drives one cycle and samples 1 time unit after the following m2 fall.
// Backpressure: not applicable; the bench only drives and observes.
module tb_cpu_write_filter;

    logic        m2 = 1'b1;
    logic        reset = 1'b1;
    logic        romsel = 1'b1;
    logic        cpu_rw_in = 1'b1;
    logic [14:0] cpu_addr_in = 15'd0;
    logic [7:0]  cpu_data_in = 8'd0;

    logic        wr_strobe, nf_strobe, ng_strobe;
    logic [14:0] wr_addr, nf_addr, ng_addr;
    logic [7:0]  wr_data, nf_data, ng_data;
    logic        ready, nf_ready, ng_ready;
    logic [7:0]  drop_count, nf_drop, ng_drop;

    int n_cmp = 0;
    int n_err = 0;
    int strobes = 0;
    int nf_strobes = 0;

    always #5 m2 = ~m2;

    cpu_write_filter dut (
        .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready), .drop_count(drop_count)
    );

    cpu_write_filter #(.FILTER_RMW(1'b0)) dut_nf (
        .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .wr_strobe(nf_strobe), .wr_addr(nf_addr), .wr_data(nf_data),
        .ready(nf_ready), .drop_count(nf_drop)
    );

    cpu_write_filter #(.GUARD_CYCLES(0)) dut_ng (
        .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .wr_strobe(ng_strobe), .wr_addr(ng_addr), .wr_data(ng_data),
        .ready(ng_ready), .drop_count(ng_drop)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle, let one m2 falling edge sample it, then settle.
    task automatic bus(input logic wr, input logic [14:0] a, input logic [7:0] d, input logic rs);
        cpu_rw_in   = ~wr;
        cpu_addr_in = a;
        cpu_data_in = d;
        romsel      = rs;
        @(negedge m2);
        #1;
    endtask

    task automatic idle();
        bus(1'b0, 15'h0000, 8'h00, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_strobe"}, 32'(wr_strobe), 32'd0);
        check_eq({tag, "_addr"},   32'(wr_addr),   32'd0);
        check_eq({tag, "_data"},   32'(wr_data),   32'd0);
        check_eq({tag, "_drop"},   32'(drop_count), 32'd0);
        check_eq({tag, "_ready"},  32'(ready),     32'd0);
        check_eq({tag, "_ng_ready"}, 32'(ng_ready), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge m2);
        #1;
        check_reset_values("rst");
        #2 reset = 1'b0;

        // Guard period: edge 1 write is taken only by the zero-guard instance
        bus(1'b1, 15'h4100, 8'h77, 1'b1);
        check_eq("g1_strobe", 32'(wr_strobe), 32'd0);
        check_eq("g1_ng_strobe", 32'(ng_strobe), 32'd1);
        check_eq("g1_ng_data", 32'(ng_data), 32'h77);
        for (int e = 2; e <= 9; e++) idle();
        check_eq("g9_ready", 32'(ready), 32'd0);
        bus(1'b1, 15'h4100, 8'h05, 1'b1);
        check_eq("g10_strobe", 32'(wr_strobe), 32'd0);
        check_eq("g10_data", 32'(wr_data), 32'd0);
        for (int e = 11; e <= 15; e++) idle();
        check_eq("g15_ready", 32'(ready), 32'd0);
        idle();
        check_eq("g16_ready", 32'(ready), 32'd1);
        for (int e = 17; e <= 19; e++) idle();
        bus(1'b1, 15'h4100, 8'h06, 1'b1);
        check_eq("g20_strobe", 32'(wr_strobe), 32'd1);
        check_eq("g20_data", 32'(wr_data), 32'h06);
        check_eq("g20_addr", 32'(wr_addr), 32'h4100);
        idle();
        check_eq("g21_strobe", 32'(wr_strobe), 32'd0);
        check_eq("g21_data_held", 32'(wr_data), 32'h06);

        // Address decode
        bus(1'b1, 15'h4100, 8'h0A, 1'b1);
        check_eq("d4100_strobe", 32'(wr_strobe), 32'd1);
        check_eq("d4100_data", 32'(wr_data), 32'h0A);
        idle();
        bus(1'b1, 15'h6100, 8'h0A, 1'b1);
        check_eq("d6100_strobe", 32'(wr_strobe), 32'd0);
        check_eq("d6100_addr", 32'(wr_addr), 32'h4100);
        idle();
        bus(1'b1, 15'h4000, 8'h0A, 1'b1);
        check_eq("d4000_strobe", 32'(wr_strobe), 32'd0);
        idle();
        bus(1'b1, 15'h4100, 8'h0A, 1'b0);
        check_eq("dC100_strobe", 32'(wr_strobe), 32'd0);
        check_eq("dC100_addr", 32'(wr_addr), 32'h4100);
        check_eq("dC100_data", 32'(wr_data), 32'h0A);
        idle();
        bus(1'b0, 15'h4100, 8'hEE, 1'b1);
        check_eq("dread_strobe", 32'(wr_strobe), 32'd0);
        check_eq("dread_data", 32'(wr_data), 32'h0A);
        idle();

        // RMW filtering on the default instance, pass-through on the unfiltered one
        bus(1'b1, 15'h4100, 8'h03, 1'b1);
        check_eq("rmw1_strobe", 32'(wr_strobe), 32'd1);
        check_eq("rmw1_data", 32'(wr_data), 32'h03);
        check_eq("rmw1_nf_strobe", 32'(nf_strobe), 32'd1);
        bus(1'b1, 15'h4100, 8'h0F, 1'b1);
        check_eq("rmw2_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rmw2_data", 32'(wr_data), 32'h03);
        check_eq("rmw2_drop", 32'(drop_count), 32'd1);
        check_eq("rmw2_nf_strobe", 32'(nf_strobe), 32'd1);
        check_eq("rmw2_nf_data", 32'(nf_data), 32'h0F);
        check_eq("rmw2_nf_drop", 32'(nf_drop), 32'd0);
        idle();
        check_eq("rmw3_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rmw3_nf_strobe", 32'(nf_strobe), 32'd0);

        // Drop counter saturation over 300 consecutive matching writes
        for (int j = 1; j <= 300; j++) begin
            bus(1'b1, 15'h4100, 8'(j), 1'b1);
            if (wr_strobe) strobes++;
            if (nf_strobe) nf_strobes++;
            if (j == 254) check_eq("sat254_drop", 32'(drop_count), 32'd254);
            if (j == 255) check_eq("sat255_drop", 32'(drop_count), 32'd255);
        end
        check_eq("sat_strobes", 32'(strobes), 32'd1);
        check_eq("sat_drop", 32'(drop_count), 32'd255);
        check_eq("sat_data", 32'(wr_data), 32'h01);
        check_eq("sat_nf_strobes", 32'(nf_strobes), 32'd300);
        check_eq("sat_nf_data", 32'(nf_data), 32'h2C);
        check_eq("sat_nf_drop", 32'(nf_drop), 32'd0);
        idle();

        // Mid-operation reset while the strobe is high
        bus(1'b1, 15'h4100, 8'h5A, 1'b1);
        check_eq("mr_pre_strobe", 32'(wr_strobe), 32'd1);
        check_eq("mr_pre_data", 32'(wr_data), 32'h5A);
        reset = 1'b1;
        #1;
        check_reset_values("mr_async");
        @(negedge m2);
        @(negedge m2);
        #1;
        check_reset_values("mr_held");
        cpu_rw_in = 1'b1;
        #2 reset = 1'b0;
        for (int e = 1; e <= 15; e++) idle();
        check_eq("mr15_ready", 32'(ready), 32'd0);
        bus(1'b1, 15'h4100, 8'h11, 1'b1);
        check_eq("mr16_ready", 32'(ready), 32'd1);
        check_eq("mr16_strobe", 32'(wr_strobe), 32'd0);
        idle();
        bus(1'b1, 15'h4100, 8'h22, 1'b1);
        check_eq("mr18_strobe", 32'(wr_strobe), 32'd1);
        check_eq("mr18_data", 32'(wr_data), 32'h22);
        idle();
        check_eq("mr19_strobe", 32'(wr_strobe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
